main_control_fsm: RTL and testbench

- Multicycle main controller for the MIPS datapath.
- Decodes the 6-bit instruction opcode and sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath enable and mux select, plus the 2-bit ALUOp that feeds the ALU decoder stage directly downstream.
- Moore machine: all outputs are a pure function of the current state.

---
 rtl/main_control_fsm_pkg.sv | 82 ++++++++
 rtl/main_control_fsm_if.sv | 47 ++++
 rtl/main_control_fsm_control_word_decoder.sv | 81 ++++++++
 rtl/main_control_fsm.sv | 96 +++++++++
 tb/tb_main_control_fsm.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/main_control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// main_control_fsm_pkg
// Shared definitions for the multicycle MIPS main controller:
//   - state encodings FETCH..JUMP (4-bit, 12 of 16 codes used)
//   - opcode constants for the supported instructions
//   - ALUOp, PCSrc and ALUSrcB select codes
//   - ctrl_t, the packed control word produced for every state
// -----------------------------------------------------------------------------
package main_control_fsm_pkg;

  localparam int OPCODE_SIZE = 6;
  localparam int STATE_WIDTH = 4;

  // State encodings. These values are visible on the State debug output,
  // so they are fixed rather than left to the synthesis tool.
  localparam logic [STATE_WIDTH-1:0] FETCH   = 4'd0;
  localparam logic [STATE_WIDTH-1:0] DECODE  = 4'd1;
  localparam logic [STATE_WIDTH-1:0] MEMADR  = 4'd2;
  localparam logic [STATE_WIDTH-1:0] MEMRD   = 4'd3;
  localparam logic [STATE_WIDTH-1:0] MEMWB   = 4'd4;
  localparam logic [STATE_WIDTH-1:0] MEMWR   = 4'd5;
  localparam logic [STATE_WIDTH-1:0] EXECUTE = 4'd6;
  localparam logic [STATE_WIDTH-1:0] ALUWB   = 4'd7;
  localparam logic [STATE_WIDTH-1:0] BRANCH  = 4'd8;
  localparam logic [STATE_WIDTH-1:0] ADDIEX  = 4'd9;
  localparam logic [STATE_WIDTH-1:0] ADDIWB  = 4'd10;
  localparam logic [STATE_WIDTH-1:0] JUMP    = 4'd11;

  // Instruction opcodes, Instr[31:26]
  localparam logic [OPCODE_SIZE-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_SIZE-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_SIZE-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_SIZE-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_SIZE-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_SIZE-1:0] OP_J     = 6'b000010;

  // ALUOp codes consumed by the downstream ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PC source select
  localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
  localparam logic [1:0] PCSRC_JUMP      = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Full datapath control word for one state
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  // Control word of the FETCH state; also used for reset and for the
  // unused state codes so those never drive a stray write.
  function automatic ctrl_t fetch_ctrl();
    ctrl_t c;
    c           = '0;
    c.ir_write  = 1'b1;
    c.pc_write  = 1'b1;
    c.alu_src_b = SRCB_FOUR;
    c.alu_op    = ALUOP_ADD;
    c.pc_src    = PCSRC_ALURESULT;
    return c;
  endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// -----------------------------------------------------------------------------
// main_control_fsm_if
// Bundle between the main controller and the multicycle datapath.
//   Op        : opcode from the instruction register (datapath -> controller)
//   IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc,
//   ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite
//             : datapath controls (controller -> datapath)
//   State     : current controller state, debug/verification only
// Modports:
//   master : the controller side
//   slave  : the datapath side
// -----------------------------------------------------------------------------
interface main_control_fsm_if #(
  parameter int Opcode_Size = main_control_fsm_pkg::OPCODE_SIZE,
  parameter int State_Width = main_control_fsm_pkg::STATE_WIDTH
);

  logic [Opcode_Size-1:0] Op;
  logic                   IorD;
  logic                   MemWrite;
  logic                   IRWrite;
  logic                   PCWrite;
  logic                   Branch;
  logic [1:0]             PCSrc;
  logic                   ALUSrcA;
  logic [1:0]             ALUSrcB;
  logic [1:0]             ALUOp;
  logic                   RegDst;
  logic                   MemtoReg;
  logic                   RegWrite;
  logic [State_Width-1:0] State;

  modport master (
    input  Op,
    output IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc,
    output ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite,
    output State
  );

  modport slave (
    output Op,
    input  IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc,
    input  ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite,
    input  State
  );

endinterface

// File: rtl/main_control_fsm_control_word_decoder.sv
// -----------------------------------------------------------------------------
// main_control_fsm_control_word_decoder
// Purely combinational Moore output map: current state -> control word.
//   state : current controller state
//   ctrl  : control word for that state (fields not set in a row stay 0)
// Unused codes 12..15 decode as FETCH, matching where the FSM goes next.
// -----------------------------------------------------------------------------
module main_control_fsm_control_word_decoder
  import main_control_fsm_pkg::*;
(
  input  logic [STATE_WIDTH-1:0] state,
  output ctrl_t                  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl = fetch_ctrl();
      end
      DECODE: begin
        // PC+4 is already in PC; ALUOut receives the branch target here.
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.iord = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      BRANCH: begin
        // Compare rs/rt by subtraction; PC takes ALUOut (target) when Zero.
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_src    = PCSRC_ALUOUT;
      end
      ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      default: begin
        ctrl = fetch_ctrl();
      end
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// -----------------------------------------------------------------------------
// main_control_fsm
// Multicycle MIPS main controller (Moore machine). Sequences each instruction
// through fetch / decode / execute / memory / writeback and drives every
// datapath enable and mux select from the current state only.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset, returns to FETCH immediately
//   bus : main_control_fsm_if.master -- Op in, all controls and State out
// Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3,
// illegal opcode 2 (FETCH, DECODE, back to FETCH with no write).
// -----------------------------------------------------------------------------
module main_control_fsm
  import main_control_fsm_pkg::*;
#(
  parameter int Opcode_Size = OPCODE_SIZE,
  parameter int State_Width = STATE_WIDTH
) (
  input logic                clk,
  input logic                rst,
  main_control_fsm_if.master bus
);

  logic [STATE_WIDTH-1:0] state_reg;
  logic [STATE_WIDTH-1:0] state_next;
  ctrl_t                  ctrl;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. Op is only looked at in DECODE and MEMADR; the IR
  // loads only in FETCH, so Op is stable in both.
  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH: begin
        state_next = DECODE;
      end
      DECODE: begin
        case (bus.Op)
          Opcode_Size'(OP_LW),
          Opcode_Size'(OP_SW):    state_next = MEMADR;
          Opcode_Size'(OP_RTYPE): state_next = EXECUTE;
          Opcode_Size'(OP_BEQ):   state_next = BRANCH;
          Opcode_Size'(OP_ADDI):  state_next = ADDIEX;
          Opcode_Size'(OP_J):     state_next = JUMP;
          // Unknown opcode: drop the instruction, nothing written.
          default:                state_next = FETCH;
        endcase
      end
      MEMADR: begin
        state_next = (bus.Op == Opcode_Size'(OP_LW)) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        state_next = MEMWB;
      end
      EXECUTE: begin
        state_next = ALUWB;
      end
      ADDIEX: begin
        state_next = ADDIWB;
      end
      // MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP and the unused codes
      // 12..15 all return to FETCH.
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Output logic: state -> control word
  main_control_fsm_control_word_decoder u_decoder (
    .state (state_reg),
    .ctrl  (ctrl)
  );

  assign bus.IorD     = ctrl.iord;
  assign bus.MemWrite = ctrl.mem_write;
  assign bus.IRWrite  = ctrl.ir_write;
  assign bus.PCWrite  = ctrl.pc_write;
  assign bus.Branch   = ctrl.branch;
  assign bus.PCSrc    = ctrl.pc_src;
  assign bus.ALUSrcA  = ctrl.alu_src_a;
  assign bus.ALUSrcB  = ctrl.alu_src_b;
  assign bus.ALUOp    = ctrl.alu_op;
  assign bus.RegDst   = ctrl.reg_dst;
  assign bus.MemtoReg = ctrl.mem_to_reg;
  assign bus.RegWrite = ctrl.reg_write;
  assign bus.State    = State_Width'(state_reg);

endmodule

// File: tb/tb_main_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_main_control_fsm
// Self-checking bench for main_control_fsm: directed instruction table,
// randomized opcode stream against an instruction-level model, and
// hand-written sequences for async reset and an unused state code.
// -----------------------------------------------------------------------------
module tb_main_control_fsm;
  import main_control_fsm_pkg::*;

  typedef int path_q[$];

  typedef struct {
    string      name;
    logic [5:0] op;
    int         len;
    int         path [6];
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  main_control_fsm_if bus_if ();

  main_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Observed control word, field order matching exp_row()
  logic [14:0] obs;
  assign obs = {bus_if.IorD, bus_if.MemWrite, bus_if.IRWrite, bus_if.PCWrite,
                bus_if.Branch, bus_if.PCSrc, bus_if.ALUSrcA, bus_if.ALUSrcB,
                bus_if.ALUOp, bus_if.RegDst, bus_if.MemtoReg, bus_if.RegWrite};

  // Output row of each state, written out field by field from the table
  // of state rows; any field not named in a row is 0.
  function automatic logic [14:0] exp_row(input int s);
    logic iord, memw, irw, pcw, br, srca, rdst, m2r, regw;
    logic [1:0] pcsrc, srcb, aluop;
    iord = 0; memw = 0; irw = 0; pcw = 0; br = 0; srca = 0;
    rdst = 0; m2r = 0; regw = 0; pcsrc = 2'b00; srcb = 2'b00; aluop = 2'b00;
    case (s)
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  iord = 1;
      4:  begin regw = 1; m2r = 1; end
      5:  begin iord = 1; memw = 1; end
      6:  begin srca = 1; aluop = 2'b10; end
      7:  begin regw = 1; rdst = 1; end
      8:  begin srca = 1; aluop = 2'b01; br = 1; pcsrc = 2'b01; end
      9:  begin srca = 1; srcb = 2'b10; end
      10: regw = 1;
      11: begin pcw = 1; pcsrc = 2'b10; end
      default: begin irw = 1; pcw = 1; srcb = 2'b01; end // FETCH and 12..15
    endcase
    return {iord, memw, irw, pcw, br, pcsrc, srca, srcb, aluop, rdst, m2r, regw};
  endfunction

  // Instruction-level reference: every instruction is FETCH, DECODE and
  // then a class-specific tail of steps.
  function automatic path_q model_path(input logic [5:0] op);
    path_q p;
    p = '{0, 1};
    case (op)
      6'b100011: p = {p, 2, 3, 4};   // lw
      6'b101011: p = {p, 2, 5};      // sw
      6'b000000: p = {p, 6, 7};      // R-type
      6'b001000: p = {p, 9, 10};     // addi
      6'b000100: p = {p, 8};         // beq
      6'b000010: p = {p, 11};        // j
      default:   ;                   // illegal: straight back to FETCH
    endcase
    return p;
  endfunction

  task automatic check_cycle(input string tag, input int exp_s);
    logic [14:0] want;
    want = exp_row(exp_s);
    checks++;
    if (bus_if.State !== 4'(exp_s)) begin
      errors++;
      $display("FAIL %s state: got %0d, expected %0d", tag, bus_if.State, exp_s);
    end
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s ctrl in state %0d: got %b, expected %b", tag, exp_s, obs, want);
    end
  endtask

  // Called at a falling edge with the DUT in FETCH. Checks every cycle of
  // the instruction and returns at the falling edge of the next FETCH.
  task automatic run_instr(input string tag, input logic [5:0] op, input path_q p);
    bus_if.Op = op;
    for (int i = 0; i < p.size(); i++) begin
      check_cycle($sformatf("%s[%0d]", tag, i), p[i]);
      @(negedge clk);
    end
  endtask

  vec_t vecs [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    path_q p;
    logic [5:0] op;

    // Directed vectors: opcode, cycles per instruction, state sequence
    vecs[0] = '{name: "lw",      op: 6'b100011, len: 5, path: '{0, 1, 2, 3, 4, 0}};
    vecs[1] = '{name: "sw",      op: 6'b101011, len: 4, path: '{0, 1, 2, 5, 0, 0}};
    vecs[2] = '{name: "rtype",   op: 6'b000000, len: 4, path: '{0, 1, 6, 7, 0, 0}};
    vecs[3] = '{name: "beq",     op: 6'b000100, len: 3, path: '{0, 1, 8, 0, 0, 0}};
    vecs[4] = '{name: "j",       op: 6'b000010, len: 3, path: '{0, 1, 11, 0, 0, 0}};
    vecs[5] = '{name: "addi",    op: 6'b001000, len: 4, path: '{0, 1, 9, 10, 0, 0}};
    vecs[6] = '{name: "ill_3f",  op: 6'b111111, len: 2, path: '{0, 1, 0, 0, 0, 0}};
    vecs[7] = '{name: "ill_01",  op: 6'b000001, len: 2, path: '{0, 1, 0, 0, 0, 0}};

    rst       = 1'b1;
    bus_if.Op = 6'b111111;
    @(negedge clk);
    check_cycle("reset", 0);
    rst = 1'b0;

    // Directed table
    foreach (vecs[v]) begin
      p = {};
      for (int i = 0; i < vecs[v].len; i++) p.push_back(vecs[v].path[i]);
      run_instr(vecs[v].name, vecs[v].op, p);
      $display("instr %-7s op=%b cycles=%0d", vecs[v].name, vecs[v].op, vecs[v].len);
    end
    check_cycle("table_end", 0);

    // Randomized opcode stream against the instruction-level model
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_RTYPE;
        3: op = OP_BEQ;
        4: op = OP_J;
        5: op = OP_ADDI;
        default: op = 6'($urandom);
      endcase
      p = model_path(op);
      run_instr($sformatf("rand%0d", n), op, p);
      $display("instr rand%0d op=%b cycles=%0d", n, op, p.size());
    end
    check_cycle("rand_end", 0);

    // Async reset in the middle of a lw, between clock edges
    bus_if.Op = OP_LW;
    check_cycle("rst_mid_fetch", 0);
    @(negedge clk);
    check_cycle("rst_mid_decode", 1);
    #1 rst = 1'b1;
    #1 check_cycle("rst_mid_async", 0);
    @(negedge clk);
    check_cycle("rst_mid_hold", 0);
    rst = 1'b0;
    run_instr("post_rst_sw", OP_SW, model_path(OP_SW));
    $display("instr reset mid-lw, then sw");

    // Unused state code 13: FETCH outputs, FETCH on the next edge
    bus_if.Op = OP_LW;
    for (int i = 0; i < 4; i++) begin
      check_cycle($sformatf("pre13[%0d]", i), i);
      @(negedge clk);
    end
    check_cycle("pre13[4]", 4);
    force dut.state_reg = 4'd13;
    #1 check_cycle("state13", 13);
    release dut.state_reg;
    @(negedge clk);
    check_cycle("from13", 0);
    $display("instr unused state 13 -> FETCH");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
